mem_fill_arbiter: RTL and testbench
===================================

# mem_fill_arbiter

Arbitrates the single main-memory port between the instruction-cache and data-cache controllers of the pipelined 16-bit CPU. It serves write-through stores and sequences 8-word block fills by issuing pipelined reads to the fixed-latency memory. Returned words are forwarded to the granted cache with a word offset. It sits between the two cache controllers and the memory instance, below the pipeline's stall logic.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS, 8, words per cache block (power of two)
- MEM_LAT, 4, cycles from read issue to `mem_rvalid`

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_miss_req  in  1  I-cache miss; held high until `i_fill_done`
- i_miss_addr  in  ADDR_W  I-cache miss address
- d_miss_req  in  1  D-cache miss; held high until `d_fill_done`
- d_miss_addr  in  ADDR_W  D-cache miss address
- d_wr_req  in  1  store request; held high until `d_wr_ack`
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- d_wr_ack  out  1  one-cycle pulse, store issued
- fill_data  out  DATA_W  returned word (shared by both caches)
- fill_off  out  log2(WORDS)  word offset of `fill_data` within the block
- i_fill_valid / d_fill_valid  out  1  `fill_data` belongs to that cache this cycle
- i_fill_done / d_fill_done  out  1  pulse with the last valid word of the block
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  write when high, read when low (qualified by `mem_en`)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  `mem_rdata` valid; asserted MEM_LAT cycles after a read issue
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, FILL, DONE.
- IDLE priority: `d_wr_req` > miss grant. Between misses, round-robin on the `last_grant` register. The requester that was not granted last wins a tie. `last_grant` resets to I, so D wins the first tie.
- IDLE -> WRITE on a store. WRITE lasts one cycle and drives `mem_en=1`, `mem_wr=1`, `mem_addr=d_wr_addr`, `mem_wdata=d_wr_data`, with `d_wr_ack=1`. It then returns to IDLE.
- IDLE -> FILL on a miss grant. On entry, latch `owner` and `base = addr & ~(2*WORDS-1)`.
- In FILL, issue counter `iss` runs 0..WORDS-1. Each cycle with `iss<WORDS` drives `mem_en=1`, `mem_wr=0`, `mem_addr = base + 2*iss`.
- In FILL, receive counter `rcv` increments on each `mem_rvalid`. For each `mem_rvalid`:
  - `fill_data = mem_rdata`
  - `fill_off = rcv`
  - `<owner>_fill_valid = 1`
- When `rcv == WORDS-1` and `mem_rvalid`, pulse `<owner>_fill_done` and go to DONE.
- DONE lasts one cycle. It ignores all requests (the requester drops its req) and updates `last_grant = owner`. It then goes to IDLE.
- Stores arriving during FILL wait; no preemption.
- `fill_*` and `*_valid` outputs are 0 outside FILL. `mem_rvalid` outside FILL is ignored.
- Address arithmetic is modulo 2^ADDR_W; a block at 0xFFF0 wraps nothing, since `base` is aligned.

## Timing
- Reset values: state IDLE, `iss=rcv=0`, `last_grant=I`, and every output 0.
- Reset mid-FILL aborts immediately with no done pulse. Memory shares `rst`, so no stale `mem_rvalid` follows.
- Fill latency: request seen in IDLE at cycle T.
  - Reads issue at T+1..T+WORDS.
  - Word k returns at T+1+k+MEM_LAT.
  - Done pulses at T+WORDS+MEM_LAT (T+12 by default).
  - DONE at T+13, IDLE at T+14.
- Store latency: request at T gives the ack/write at T+1, and IDLE at T+2.
- `fill_*` outputs are combinational from `mem_rdata`/`mem_rvalid` and the registered state. All other outputs are registered-state decodes only.

## Structure
- Shared package `wisc_mem_pkg` holds:
  - the state enum `arb_state_t` (IDLE, WRITE, FILL, DONE)
  - the `req_id_t` owner encoding (REQ_I, REQ_D)
  - the default constants WORDS and MEM_LAT
- One sub-module, `fill_seq`, holds the issue/receive counters. It takes `start`, `base`, and `mem_rvalid`, and produces `rd_en`, `rd_addr`, `off`, and `last`.
- Arbitration and the FSM live in `mem_fill_arbiter`.

## Test plan
- **I-miss alone:** `i_miss_addr=0x0036` at T.
  - Reads go to 0x0030..0x003E at T+1..T+8.
  - `i_fill_valid` appears with `fill_off` 0..7 at T+5..T+12.
  - `i_fill_done` pulses at T+12.
  - `d_fill_valid` stays 0 throughout.
- **Simultaneous misses after reset:** `i_miss_addr=0x0100`, `d_miss_addr=0x2008`.
  - D is served first from base 0x2000, then I from base 0x0100.
  - I's first read issues at T+15.
- **Store during D fill:** `d_wr_req` (0x4002, 0xBEEF) arrives mid-fill.
  - No write until after DONE.
  - Then `mem_wr=1` with 0x4002/0xBEEF and a single `d_wr_ack`.
- **Store vs. I-miss tie in IDLE:** the store goes first; the I fill starts 2 cycles later.
- **Reset mid-fill:** `rst` asserted at fill cycle 6.
  - Next cycle: all outputs 0, IDLE, no done pulse.
  - A fresh I-miss then completes normally with 8 words.
- **Wrap-around block:** `d_miss_addr=0xFFFE` reads 0xFFF0..0xFFFE in order, with `fill_off` 7 last.

Source files
------------

// File: rtl/wisc_mem_pkg.sv
// Shared types and default sizing for the main-memory arbiter.
// Owner and state encodings are used by the arbiter and its bench.
package wisc_mem_pkg;

    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

endpackage

// File: rtl/mem_fill_arbiter_fill_seq.sv
// Issue/receive counters for one cache block fill.
// Reads step one word at a time from the latched, block-aligned base.
module fill_seq #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_run,
    input  logic [ADDR_W-1:0]        i_base,
    input  logic                     i_rvalid,
    output logic                     o_rd_en,
    output logic [ADDR_W-1:0]        o_rd_addr,
    output logic [$clog2(WORDS)-1:0] o_off,
    output logic                     o_last
);
    localparam int OFF_W = $clog2(WORDS);

    logic [OFF_W:0]    r_iss;
    logic [OFF_W-1:0]  r_rcv;
    logic [ADDR_W-1:0] r_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss  <= '0;
            r_rcv  <= '0;
            r_base <= '0;
        end else if (i_start) begin
            r_iss  <= '0;
            r_rcv  <= '0;
            r_base <= i_base;
        end else begin
            if (o_rd_en)
                r_iss <= r_iss + (OFF_W+1)'(1);
            if (i_rvalid)
                r_rcv <= r_rcv + OFF_W'(1);
        end
    end

    // The extra MSB of the issue count marks all reads sent.
    assign o_rd_en   = i_run && !r_iss[OFF_W];
    assign o_rd_addr = r_base + ADDR_W'({r_iss[OFF_W-1:0], 1'b0});
    assign o_off     = r_rcv;
    assign o_last    = i_rvalid && (r_rcv == OFF_W'(WORDS-1));

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the memory port between I/D cache fills and D-cache stores.
// Stores win in IDLE; competing misses alternate on the last grant.
module mem_fill_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = wisc_mem_pkg::WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_miss_req,
    input  logic [ADDR_W-1:0]        i_miss_addr,
    input  logic                     d_miss_req,
    input  logic [ADDR_W-1:0]        d_miss_addr,
    input  logic                     d_wr_req,
    input  logic [ADDR_W-1:0]        d_wr_addr,
    input  logic [DATA_W-1:0]        d_wr_data,
    output logic                     d_wr_ack,
    output logic [DATA_W-1:0]        fill_data,
    output logic [$clog2(WORDS)-1:0] fill_off,
    output logic                     i_fill_valid,
    output logic                     d_fill_valid,
    output logic                     i_fill_done,
    output logic                     d_fill_done,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_rvalid,
    output logic                     busy
);
    localparam int OFF_W = $clog2(WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2*WORDS-1);

    arb_state_t        r_state;
    req_id_t           r_owner;
    req_id_t           r_last;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    req_id_t           w_pick;
    logic              w_start;
    logic [ADDR_W-1:0] w_base;
    logic              w_is_wr;
    logic              w_is_fill;
    logic              w_rvalid;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [OFF_W-1:0]  w_off;
    logic              w_last;

    always_comb begin
        w_pick = REQ_I;
        if (i_miss_req && d_miss_req)
            w_pick = (r_last == REQ_I) ? REQ_D : REQ_I;
        else if (d_miss_req)
            w_pick = REQ_D;
    end

    assign w_start   = (r_state == IDLE) && !d_wr_req
                    && (i_miss_req || d_miss_req);
    assign w_base    = ((w_pick == REQ_D) ? d_miss_addr : i_miss_addr)
                    & BLK_MASK;
    assign w_is_wr   = (r_state == WRITE);
    assign w_is_fill = (r_state == FILL);
    assign w_rvalid  = w_is_fill && mem_rvalid;

    fill_seq #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_run     (w_is_fill),
        .i_base    (w_base),
        .i_rvalid  (w_rvalid),
        .o_rd_en   (w_rd_en),
        .o_rd_addr (w_rd_addr),
        .o_off     (w_off),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= REQ_I;
            r_last    <= REQ_I;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (d_wr_req) begin
                        r_state   <= WRITE;
                        r_wr_addr <= d_wr_addr;
                        r_wr_data <= d_wr_data;
                    end else if (w_start) begin
                        r_state <= FILL;
                        r_owner <= w_pick;
                    end
                end
                WRITE: r_state <= IDLE;
                FILL:  if (w_last) r_state <= DONE;
                DONE: begin
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store operands are captured so the write cycle decodes registers only.
    assign d_wr_ack     = w_is_wr;
    assign mem_en       = w_is_wr || w_rd_en;
    assign mem_wr       = w_is_wr;
    assign mem_addr     = w_is_wr ? r_wr_addr : (w_rd_en ? w_rd_addr : '0);
    assign mem_wdata    = w_is_wr ? r_wr_data : '0;
    assign busy         = (r_state != IDLE);

    assign fill_data    = w_rvalid ? mem_rdata : '0;
    assign fill_off     = w_rvalid ? w_off : '0;
    assign i_fill_valid = w_rvalid && (r_owner == REQ_I);
    assign d_fill_valid = w_rvalid && (r_owner == REQ_D);
    assign i_fill_done  = w_last && (r_owner == REQ_I);
    assign d_fill_done  = w_last && (r_owner == REQ_D);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency memory model.
// Read data is the read address XOR 16'hA5A5.
module tb_mem_fill_arbiter;

    localparam int LAT = wisc_mem_pkg::MEM_LAT;

    logic        clk;
    logic        rst;
    logic        i_miss_req;
    logic [15:0] i_miss_addr;
    logic        d_miss_req;
    logic [15:0] d_miss_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic        d_wr_ack;
    logic [15:0] fill_data;
    logic [2:0]  fill_off;
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    mem_fill_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_miss_req   (i_miss_req),
        .i_miss_addr  (i_miss_addr),
        .d_miss_req   (d_miss_req),
        .d_miss_addr  (d_miss_addr),
        .d_wr_req     (d_wr_req),
        .d_wr_addr    (d_wr_addr),
        .d_wr_data    (d_wr_data),
        .d_wr_ack     (d_wr_ack),
        .fill_data    (fill_data),
        .fill_off     (fill_off),
        .i_fill_valid (i_fill_valid),
        .d_fill_valid (d_fill_valid),
        .i_fill_done  (i_fill_done),
        .d_fill_done  (d_fill_done),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [LAT-1:0] pv;
    logic [15:0]    pa [LAT];

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], mem_en && !mem_wr};
            pa[0] <= mem_addr;
            for (int i = 1; i < LAT; i++)
                pa[i] <= pa[i-1];
        end
    end

    assign mem_rvalid = pv[LAT-1];
    assign mem_rdata  = pa[LAT-1] ^ 16'hA5A5;

    wire [58:0] all_outs = {mem_en, mem_wr, mem_addr, mem_wdata, d_wr_ack,
                            fill_data, fill_off, i_fill_valid, d_fill_valid,
                            i_fill_done, d_fill_done, busy};

    task automatic clear_inputs();
        i_miss_req  = 1'b0;
        i_miss_addr = 16'h0;
        d_miss_req  = 1'b0;
        d_miss_addr = 16'h0;
        d_wr_req    = 1'b0;
        d_wr_addr   = 16'h0;
        d_wr_data   = 16'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst        = 1'b1;
        i_miss_req = 1'b1;
        d_wr_req   = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if (all_outs !== '0) begin
            errs++;
            $display("FAIL reset_hold outs=%h expected 0", all_outs);
        end
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (all_outs !== '0) begin
            errs++;
            $display("FAIL reset_idle outs=%h expected 0", all_outs);
        end
    endtask

    task automatic test_i_miss();
        logic [15:0] ea;
        logic [15:0] ed;
        logic        exp_en;
        logic        exp_v;
        logic        exp_dn;
        logic        exp_bz;
        i_miss_addr = 16'h0036;
        i_miss_req  = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            ea     = 16'h0030 + 16'(2*(n-1));
            ed     = (16'h0030 + 16'(2*(n-5))) ^ 16'hA5A5;
            exp_en = (n <= 8);
            exp_v  = (n >= 5) && (n <= 12);
            exp_dn = (n == 12);
            exp_bz = (n <= 13);
            vecs++;
            if (mem_en !== exp_en || mem_wr !== 1'b0
                || (exp_en && mem_addr !== ea)) begin
                errs++;
                $display("FAIL i_miss_read n=%0d en=%b wr=%b addr=%h expected en=%b wr=0 addr=%h",
                         n, mem_en, mem_wr, mem_addr, exp_en, ea);
            end
            vecs++;
            if (i_fill_valid !== exp_v || d_fill_valid !== 1'b0
                || (exp_v && (fill_off !== 3'(n-5) || fill_data !== ed))) begin
                errs++;
                $display("FAIL i_miss_fill n=%0d iv=%b dv=%b off=%0d data=%h expected iv=%b dv=0 off=%0d data=%h",
                         n, i_fill_valid, d_fill_valid, fill_off, fill_data,
                         exp_v, 3'(n-5), ed);
            end
            vecs++;
            if (i_fill_done !== exp_dn || d_fill_done !== 1'b0
                || busy !== exp_bz) begin
                errs++;
                $display("FAIL i_miss_done n=%0d idone=%b ddone=%b busy=%b expected idone=%b ddone=0 busy=%b",
                         n, i_fill_done, d_fill_done, busy, exp_dn, exp_bz);
            end
            if (n == 12)
                i_miss_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        int iw;
        int dw;
        iw = 0;
        dw = 0;
        do_reset();
        i_miss_addr = 16'h0100;
        d_miss_addr = 16'h2008;
        i_miss_req  = 1'b1;
        d_miss_req  = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            if (i_fill_valid) iw++;
            if (d_fill_valid) dw++;
            if (n == 1) begin
                vecs++;
                if (mem_en !== 1'b1 || mem_addr !== 16'h2000) begin
                    errs++;
                    $display("FAIL simul_d_first en=%b addr=%h expected en=1 addr=2000",
                             mem_en, mem_addr);
                end
            end
            if (n == 12) begin
                vecs++;
                if (d_fill_done !== 1'b1 || i_fill_done !== 1'b0) begin
                    errs++;
                    $display("FAIL simul_d_done ddone=%b idone=%b expected ddone=1 idone=0",
                             d_fill_done, i_fill_done);
                end
                d_miss_req = 1'b0;
            end
            if (n == 15) begin
                vecs++;
                if (mem_en !== 1'b1 || mem_wr !== 1'b0
                    || mem_addr !== 16'h0100) begin
                    errs++;
                    $display("FAIL simul_i_start en=%b wr=%b addr=%h expected en=1 wr=0 addr=0100",
                             mem_en, mem_wr, mem_addr);
                end
            end
            if (n == 26) begin
                vecs++;
                if (i_fill_done !== 1'b1) begin
                    errs++;
                    $display("FAIL simul_i_done idone=%b expected 1", i_fill_done);
                end
                i_miss_req = 1'b0;
            end
        end
        vecs++;
        if (iw !== 8 || dw !== 8) begin
            errs++;
            $display("FAIL simul_words i=%0d d=%0d expected 8 and 8", iw, dw);
        end
    endtask

    task automatic test_store_in_fill();
        int wc;
        int ac;
        wc = 0;
        ac = 0;
        d_miss_addr = 16'h3004;
        d_miss_req  = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (mem_en && mem_wr) wc++;
            if (d_wr_ack) ac++;
            if (n == 3) begin
                d_wr_addr = 16'h4002;
                d_wr_data = 16'hBEEF;
                d_wr_req  = 1'b1;
            end
            if (n == 12) begin
                vecs++;
                if (d_fill_done !== 1'b1) begin
                    errs++;
                    $display("FAIL store_fill_done ddone=%b expected 1", d_fill_done);
                end
                d_miss_req = 1'b0;
            end
            if (n == 13) begin
                vecs++;
                if (wc !== 0 || d_wr_ack !== 1'b0) begin
                    errs++;
                    $display("FAIL store_held writes=%0d ack=%b expected 0 and 0", wc, d_wr_ack);
                end
            end
            if (n == 15) begin
                vecs++;
                if (mem_en !== 1'b1 || mem_wr !== 1'b1 || d_wr_ack !== 1'b1
                    || mem_addr !== 16'h4002 || mem_wdata !== 16'hBEEF) begin
                    errs++;
                    $display("FAIL store_write en=%b wr=%b ack=%b addr=%h wdata=%h expected 1 1 1 4002 BEEF",
                             mem_en, mem_wr, d_wr_ack, mem_addr, mem_wdata);
                end
                d_wr_req = 1'b0;
            end
        end
        vecs++;
        if (ac !== 1 || wc !== 1) begin
            errs++;
            $display("FAIL store_single acks=%0d writes=%0d expected 1 and 1", ac, wc);
        end
    endtask

    task automatic test_store_vs_miss();
        i_miss_addr = 16'h0040;
        i_miss_req  = 1'b1;
        d_wr_addr   = 16'h1234;
        d_wr_data   = 16'h5678;
        d_wr_req    = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) begin
                vecs++;
                if (d_wr_ack !== 1'b1 || mem_wr !== 1'b1
                    || mem_addr !== 16'h1234 || mem_wdata !== 16'h5678) begin
                    errs++;
                    $display("FAIL tie_store ack=%b wr=%b addr=%h wdata=%h expected 1 1 1234 5678",
                             d_wr_ack, mem_wr, mem_addr, mem_wdata);
                end
                d_wr_req = 1'b0;
            end
            if (n == 2) begin
                vecs++;
                if (busy !== 1'b0 || mem_en !== 1'b0) begin
                    errs++;
                    $display("FAIL tie_gap busy=%b en=%b expected 0 0", busy, mem_en);
                end
            end
            if (n == 3) begin
                vecs++;
                if (mem_en !== 1'b1 || mem_wr !== 1'b0
                    || mem_addr !== 16'h0040) begin
                    errs++;
                    $display("FAIL tie_fill en=%b wr=%b addr=%h expected 1 0 0040",
                             mem_en, mem_wr, mem_addr);
                end
            end
            if (n == 14) begin
                vecs++;
                if (i_fill_done !== 1'b1 || fill_off !== 3'd7) begin
                    errs++;
                    $display("FAIL tie_done idone=%b off=%0d expected 1 7",
                             i_fill_done, fill_off);
                end
                i_miss_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int iw;
        int dn;
        iw = 0;
        dn = 0;
        i_miss_addr = 16'h0500;
        i_miss_req  = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (i_fill_done || d_fill_done) dn++;
            if (n >= 7 && i_fill_valid) iw++;
            if (n == 6)
                rst = 1'b1;
            if (n == 7) begin
                vecs++;
                if (all_outs !== '0) begin
                    errs++;
                    $display("FAIL rst_mid outs=%h expected 0", all_outs);
                end
                rst         = 1'b0;
                i_miss_addr = 16'h0600;
            end
            if (n == 19) begin
                vecs++;
                if (i_fill_done !== 1'b1 || fill_off !== 3'd7
                    || fill_data !== (16'h060E ^ 16'hA5A5)) begin
                    errs++;
                    $display("FAIL rst_refill_done idone=%b off=%0d data=%h expected 1 7 %h",
                             i_fill_done, fill_off, fill_data, 16'h060E ^ 16'hA5A5);
                end
                i_miss_req = 1'b0;
            end
        end
        vecs++;
        if (iw !== 8 || dn !== 1) begin
            errs++;
            $display("FAIL rst_refill_count words=%0d dones=%0d expected 8 and 1", iw, dn);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ea;
        d_miss_addr = 16'hFFFE;
        d_miss_req  = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            ea = 16'hFFF0 + 16'(2*(n-1));
            if (n <= 8) begin
                vecs++;
                if (mem_en !== 1'b1 || mem_addr !== ea) begin
                    errs++;
                    $display("FAIL wrap_read n=%0d en=%b addr=%h expected en=1 addr=%h",
                             n, mem_en, mem_addr, ea);
                end
            end
            if (n == 12) begin
                vecs++;
                if (d_fill_done !== 1'b1 || d_fill_valid !== 1'b1
                    || fill_off !== 3'd7 || fill_data !== 16'h5A5B) begin
                    errs++;
                    $display("FAIL wrap_last ddone=%b dv=%b off=%0d data=%h expected 1 1 7 5A5B",
                             d_fill_done, d_fill_valid, fill_off, fill_data);
                end
                d_miss_req = 1'b0;
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_i_miss();
        test_simultaneous();
        test_store_in_fill();
        test_store_vs_miss();
        test_reset_mid_fill();
        test_wrap();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
